// File: rtl/osc_tick_pkg.sv
// Shared constants and helpers for the HF-oscillator tick generator.
package osc_tick_pkg;

    localparam int HF_CLK_HZ = 6_000_000;

    // Divisor that yields target_hz ticks from the HF oscillator; 0 for an invalid target.
    function automatic int div_for_hz(input int target_hz);
        return (target_hz > 0) ? HF_CLK_HZ / target_hz : 0;
    endfunction

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/osc_tick_channel.sv
// One tick channel: divisor register, down-counter with terminal-count tick, and a square-wave flop.
module osc_tick_channel #(
    parameter int                DIV_W       = 24,
    parameter logic [DIV_W-1:0]  DEFAULT_DIV = DIV_W'(6000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             restart,
    input  logic             wr_sel,
    input  logic [DIV_W-1:0] wr_div,
    output logic             tick,
    output logic             sq
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;

    // A disabled channel (divisor 0) parks its counter at 0.
    function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] d);
        return (d == '0) ? '0 : d - ONE;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DEFAULT_DIV;
            cnt_q <= reload_of(DEFAULT_DIV);
            tick  <= 1'b0;
            sq    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (wr_sel) begin
                div_q <= wr_div;
                cnt_q <= reload_of(wr_div);
            end else if (hold || restart || (div_q == '0)) begin
                cnt_q <= reload_of(div_q);
            end else if (cnt_q == '0) begin
                tick  <= 1'b1;
                sq    <= ~sq;
                cnt_q <= reload_of(div_q);
            end else begin
                cnt_q <= cnt_q - ONE;
            end
        end
    end

endmodule

// File: rtl/osc_tick_gen.sv
// Multi-channel clock-enable generator with a startup hold that masks ticks until the oscillator settles.
module osc_tick_gen
    import osc_tick_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DIV_W          = 24,
    parameter int DEFAULT_DIV    = div_for_hz(1000),
    parameter int STARTUP_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [ch_idx_w(NUM_CH)-1:0] wr_ch,
    input  logic [DIV_W-1:0]            wr_div,
    output logic                        wr_err,
    input  logic                        sync,
    output logic                        ready,
    output logic [NUM_CH-1:0]           tick,
    output logic [NUM_CH-1:0]           sq
);

    localparam int                CH_W     = ch_idx_w(NUM_CH);
    localparam int                SU_W     = $clog2(STARTUP_CYCLES + 1);
    localparam logic [SU_W-1:0]   SU_LAST  = SU_W'(STARTUP_CYCLES - 1);
    localparam logic [CH_W:0]     NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic [SU_W-1:0] startup_q;
    logic [CH_W:0]   wr_ch_x;
    logic            wr_valid;

    // Extra bit lets the range check cover NUM_CH values that fill the index width exactly.
    assign wr_ch_x  = {1'b0, wr_ch};
    assign wr_valid = wr_en && (wr_ch_x < NUM_CH_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            startup_q <= '0;
            ready     <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_valid;
            if (!ready) begin
                if (startup_q == SU_LAST) begin
                    ready <= 1'b1;
                end else begin
                    startup_q <= startup_q + SU_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_sel;
        assign wr_sel = wr_valid && (wr_ch_x == (CH_W + 1)'(i));

        osc_tick_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DIV_W'(DEFAULT_DIV))
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .hold    (!ready),
            .restart (sync),
            .wr_sel  (wr_sel),
            .wr_div  (wr_div),
            .tick    (tick[i]),
            .sq      (sq[i])
        );
    end

endmodule

// File: tb/tb_osc_tick_gen.sv
// Scoreboard bench for osc_tick_gen: an absolute-time tick schedule model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_osc_tick_gen;

    localparam int NUM_CH         = 3;
    localparam int DIV_W          = 24;
    localparam int DEFAULT_DIV    = 4;
    localparam int STARTUP_CYCLES = 16;
    localparam int CH_W           = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [CH_W-1:0]   wr_ch = '0;
    logic [DIV_W-1:0]  wr_div = '0;
    logic              sync = 1'b0;
    logic              wr_err;
    logic              ready;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    osc_tick_gen #(
        .NUM_CH         (NUM_CH),
        .DIV_W          (DIV_W),
        .DEFAULT_DIV    (DEFAULT_DIV),
        .STARTUP_CYCLES (STARTUP_CYCLES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .wr_err (wr_err),
        .sync   (sync),
        .ready  (ready),
        .tick   (tick),
        .sq     (sq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              ready;
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] sq;
        logic              err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: each channel's next tick is an absolute edge number.
    longint t_now;
    int     m_edges;
    logic   m_ready;
    int     m_div  [NUM_CH];
    longint m_next [NUM_CH];
    logic [NUM_CH-1:0] m_sq;

    task automatic model_reset();
        m_edges = 0;
        m_ready = 1'b0;
        m_sq    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]  = DEFAULT_DIV;
            m_next[i] = -1;
        end
    endtask

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin
        t_now = 0;
        model_reset();
    end

    always @(negedge rst_n) begin
        model_reset();
        exp_q.delete();
    end

    always @(posedge clk) begin
        exp_t e;
        int   ch;
        int   nd;
        e.tick = '0;
        if (!rst_n) begin
            e.ready = 1'b0;
            e.sq    = '0;
            e.err   = 1'b0;
        end else begin
            t_now++;
            ch = int'(wr_ch);
            nd = int'(wr_div);
            e.err = wr_en && (ch >= NUM_CH);
            if (m_ready) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (wr_en && ch == i) begin
                        m_div[i]  = nd;
                        m_next[i] = (nd != 0) ? t_now + nd : -1;
                    end else if (sync) begin
                        m_next[i] = (m_div[i] != 0) ? t_now + m_div[i] : -1;
                    end else if (m_div[i] != 0 && m_next[i] == t_now) begin
                        e.tick[i] = 1'b1;
                        m_sq[i]   = ~m_sq[i];
                        m_next[i] = t_now + m_div[i];
                    end
                end
            end else begin
                if (wr_en && ch < NUM_CH) m_div[ch] = nd;
                m_edges++;
                if (m_edges == STARTUP_CYCLES) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < NUM_CH; i++)
                        m_next[i] = (m_div[i] != 0) ? t_now + m_div[i] : -1;
                end
            end
            e.ready = m_ready;
            e.sq    = m_sq;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pops++;
            check("ready",  longint'(ready),  longint'(e.ready));
            check("tick",   longint'(tick),   longint'(e.tick));
            check("sq",     longint'(sq),     longint'(e.sq));
            check("wr_err", longint'(wr_err), longint'(e.err));
        end
    end

    task automatic cyc(input logic we, input int ch, input int dv, input logic sy);
        @(negedge clk);
        wr_en  = we;
        wr_ch  = CH_W'(ch);
        wr_div = DIV_W'(dv);
        sync   = sy;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(40);
        cyc(1'b1, 1, 1, 1'b0);
        idle(10);
        cyc(1'b1, 2, 0, 1'b0);
        idle(10);
        cyc(1'b1, 2, 3, 1'b0);
        idle(10);
        cyc(1'b1, 3, 9, 1'b0);
        idle(5);
        cyc(1'b1, 0, 5, 1'b0);
        cyc(1'b1, 1, 7, 1'b0);
        idle(13);
        cyc(1'b1, 0, 2, 1'b1);
        idle(12);

        // Mid-count reset: outputs must clear without waiting for a clock edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", longint'(ready),  0);
        check("rst_tick",  longint'(tick),   0);
        check("rst_sq",    longint'(sq),     0);
        check("rst_err",   longint'(wr_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        cyc(1'b1, 0, 3, 1'b0);
        cyc(1'b0, 0, 0, 1'b1);
        idle(30);

        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(7) == 0)
                cyc(1'b1, int'($urandom_range(3)), int'($urandom_range(9)), $urandom_range(3) == 0);
            else
                cyc(1'b0, 0, 0, $urandom_range(15) == 0);
        end
        idle(5);
        check("monitor_pops_min", longint'(pops > 600), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
